// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-port fixed-latency memory between instruction fetch (IF) and load/store (LS).
// Latency : req seen at cycle t -> gnt/mem_req at t+1, rvalid at t+2+MEM_LAT, next grant no earlier than t+4+MEM_LAT.
// Backpr. : req/gnt handshake; requesters hold req until gnt, requests are ignored while a transaction is in flight.
//
// Ports:
//   clk, reset            - rising-edge clock, asynchronous active-low reset
//   if_req/if_addr        - fetch request in;  if_gnt, if_rvalid, if_rdata out
//   ls_req/ls_we/ls_addr/ls_wdata - load/store request in; ls_gnt, ls_rvalid, ls_rdata out
//   mem_req/mem_we/mem_addr/mem_wdata out, mem_rdata in (valid MEM_LAT cycles after mem_req)
//   busy                  - high whenever a transaction is in progress
//   debug                 - {if_grant_cnt, ls_grant_cnt} when ARB_DEBUG_EN is defined, else 0
//
// Optional feature macro: ARB_DEBUG_EN (grant statistics counters on the debug port).

module mem_port_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int MEM_LAT  = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    // instruction fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // load/store port
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    // memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    // status
    output logic              busy,
    output logic [31:0]       debug
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                sel_ls_q, sel_ls_d;     // 1: LS owns the current transaction
    logic                we_q, we_d;             // current transaction is a write
    logic [3:0]          lat_cnt_q, lat_cnt_d;
    logic [3:0]          starve_cnt_q, starve_cnt_d;
    logic                if_gnt_q, if_gnt_d;
    logic                ls_gnt_q, ls_gnt_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic                ls_rvalid_q, ls_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    // mem_addr/mem_wdata double as the captured request: loaded at
    // arbitration and held for the rest of the transaction.
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q, busy_d;
    logic                pick_if;

    always_comb begin
        state_d      = state_q;
        sel_ls_d     = sel_ls_q;
        we_d         = we_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        if_gnt_d     = 1'b0;
        ls_gnt_d     = 1'b0;
        mem_req_d    = 1'b0;
        mem_we_d     = 1'b0;
        if_rvalid_d  = 1'b0;
        ls_rvalid_d  = 1'b0;
        pick_if      = 1'b0;

        case (state_q)
            IDLE: begin
                if (if_req || ls_req) begin
                    // LS has priority unless IF has lost MAX_WAIT times in a row.
                    pick_if     = if_req && (!ls_req || (starve_cnt_q >= 4'(MAX_WAIT)));
                    sel_ls_d    = !pick_if;
                    we_d        = pick_if ? 1'b0 : ls_we;
                    mem_addr_d  = pick_if ? if_addr : ls_addr;
                    mem_wdata_d = pick_if ? '0 : ls_wdata;
                    // Outputs are registered, so the ISSUE-cycle strobes are
                    // prepared here and appear while the state is ISSUE.
                    mem_req_d   = 1'b1;
                    mem_we_d    = pick_if ? 1'b0 : ls_we;
                    if_gnt_d    = pick_if;
                    ls_gnt_d    = !pick_if;
                    if (pick_if) begin
                        starve_cnt_d = 4'd0;
                    end else if (if_req && (starve_cnt_q != 4'hF)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_d = 4'(MEM_LAT);
                state_d   = WAIT;
            end
            WAIT: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                // Counter was loaded with MEM_LAT in ISSUE; it reads 1 on the
                // cycle that is MEM_LAT cycles after mem_req.
                if (lat_cnt_q == 4'd1) begin
                    if (!we_q) begin
                        if (sel_ls_q) begin
                            ls_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                    if_rvalid_d = !sel_ls_q;
                    ls_rvalid_d = sel_ls_q;
                    state_d     = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            sel_ls_q     <= 1'b0;
            we_q         <= 1'b0;
            lat_cnt_q    <= 4'd0;
            starve_cnt_q <= 4'd0;
            if_gnt_q     <= 1'b0;
            ls_gnt_q     <= 1'b0;
            if_rvalid_q  <= 1'b0;
            ls_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_ls_q     <= sel_ls_d;
            we_q         <= we_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            if_gnt_q     <= if_gnt_d;
            ls_gnt_q     <= ls_gnt_d;
            if_rvalid_q  <= if_rvalid_d;
            ls_rvalid_q  <= ls_rvalid_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign if_gnt    = if_gnt_q;
    assign ls_gnt    = ls_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

`ifdef ARB_DEBUG_EN
    // Counters advance together with the registered gnt pulse, so debug
    // already includes a grant in the cycle that grant is visible.
    logic [15:0] if_grant_cnt_q, if_grant_cnt_d;
    logic [15:0] ls_grant_cnt_q, ls_grant_cnt_d;

    always_comb begin
        if_grant_cnt_d = if_grant_cnt_q;
        ls_grant_cnt_d = ls_grant_cnt_q;
        if (if_gnt_d) begin
            if_grant_cnt_d = if_grant_cnt_q + 16'd1;
        end
        if (ls_gnt_d) begin
            ls_grant_cnt_d = ls_grant_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_grant_cnt_q <= 16'd0;
            ls_grant_cnt_q <= 16'd0;
        end else begin
            if_grant_cnt_q <= if_grant_cnt_d;
            ls_grant_cnt_q <= ls_grant_cnt_d;
        end
    end

    assign debug = {if_grant_cnt_q, ls_grant_cnt_q};
`else
    assign debug = 32'h0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose : self-checking bench for mem_port_arbiter with a memory model and a transaction-level reference.
// Latency : n/a (bench); all expectations are derived from request timing rules.
// Backpr. : requesters hold req until gnt, like the real cores.

module tb_mem_port_arbiter;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int LAT = 2;
    localparam int MW  = 4;
    localparam int N   = 4096;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          if_req   = 1'b0;
    logic [AW-1:0] if_addr  = '0;
    logic          ls_req   = 1'b0;
    logic          ls_we    = 1'b0;
    logic [AW-1:0] ls_addr  = '0;
    logic [DW-1:0] ls_wdata = '0;
    logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid;
    logic [DW-1:0] if_rdata, ls_rdata;
    logic          mem_req, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [31:0]   debug;

    always #5 clk = ~clk;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .MEM_LAT (LAT),
        .MAX_WAIT(MW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_gnt   (ls_gnt),
        .ls_rvalid(ls_rvalid),
        .ls_rdata (ls_rdata),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .debug    (debug)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s cyc=%0d got=timeout want=event", name, cyc);
    endtask

    // ---------------- memory model: MEM_LAT-cycle read pipeline ----------------
    logic [DW-1:0] mem_arr [256];
    bit            wr_vld  [256];
    logic [DW-1:0] rd_pipe [LAT];
    bit            rd_vld  [LAT];

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        case (a)
            8'h10:   return 32'hDEAD_BEEF;
            8'h20:   return 32'h0BAD_C0DE;
            8'h30:   return 32'hCAFE_F00D;
            default: return {8'h5A, a, 8'hC3, ~a};
        endcase
    endfunction

    function automatic logic [DW-1:0] mem_peek(input logic [AW-1:0] a);
        return wr_vld[a] ? mem_arr[a] : init_val(a);
    endfunction

    always @(posedge clk) begin
        if (mem_req && mem_we) begin
            mem_arr[mem_addr] <= mem_wdata;
            wr_vld[mem_addr]  <= 1'b1;
        end
        rd_pipe[0] <= mem_peek(mem_addr);
        rd_vld[0]  <= mem_req && !mem_we;
        for (int i = 1; i < LAT; i++) begin
            rd_pipe[i] <= rd_pipe[i-1];
            rd_vld[i]  <= rd_vld[i-1];
        end
    end

    // Garbage outside the valid cycle exposes a wrong capture time.
    assign mem_rdata = rd_vld[LAT-1] ? rd_pipe[LAT-1] : 32'hA5A5_A5A5;

    // ---------------- reference: schedule of expected outputs per cycle ----------------
    bit            e_if_gnt [N];
    bit            e_ls_gnt [N];
    bit            e_mreq   [N];
    bit            e_we     [N];
    bit            e_busy   [N];
    bit            e_if_rv  [N];
    bit            e_ls_rv  [N];
    bit            e_upd    [N];
    logic [AW-1:0] e_addr   [N];
    logic [DW-1:0] e_wdata  [N];
    logic [DW-1:0] e_val    [N];

    int            next_free  = 0;
    int            starve_m   = 0;
    logic [DW-1:0] m_if_rdata = '0;
    logic [DW-1:0] m_ls_rdata = '0;
    logic [15:0]   m_if_cnt   = '0;
    logic [15:0]   m_ls_cnt   = '0;
    logic [31:0]   exp_dbg;
    int            mk, ms, mr;
    bit            win_if;

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                e_if_gnt[i] = 0; e_ls_gnt[i] = 0; e_mreq[i] = 0; e_we[i] = 0;
                e_busy[i] = 0; e_if_rv[i] = 0; e_ls_rv[i] = 0; e_upd[i] = 0;
            end
            next_free  = 0;
            starve_m   = 0;
            m_if_rdata = '0;
            m_ls_rdata = '0;
            m_if_cnt   = '0;
            m_ls_cnt   = '0;
            chk("rst_if_gnt", 32'(if_gnt), 32'd0);
            chk("rst_ls_gnt", 32'(ls_gnt), 32'd0);
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'd0);
            chk("rst_if_rdata", if_rdata, 32'd0);
            chk("rst_ls_rdata", ls_rdata, 32'd0);
            chk("rst_debug", debug, 32'd0);
        end else begin
            mk = cyc % N;
            if (e_if_rv[mk] && e_upd[mk]) m_if_rdata = e_val[mk];
            if (e_ls_rv[mk] && e_upd[mk]) m_ls_rdata = e_val[mk];
            if (e_if_gnt[mk]) m_if_cnt = m_if_cnt + 16'd1;
            if (e_ls_gnt[mk]) m_ls_cnt = m_ls_cnt + 16'd1;
`ifdef ARB_DEBUG_EN
            exp_dbg = {m_if_cnt, m_ls_cnt};
`else
            exp_dbg = 32'h0;
`endif
            chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt[mk]));
            chk("ls_gnt", 32'(ls_gnt), 32'(e_ls_gnt[mk]));
            chk("mem_req", 32'(mem_req), 32'(e_mreq[mk]));
            chk("busy", 32'(busy), 32'(e_busy[mk]));
            chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv[mk]));
            chk("ls_rvalid", 32'(ls_rvalid), 32'(e_ls_rv[mk]));
            chk("if_rdata", if_rdata, m_if_rdata);
            chk("ls_rdata", ls_rdata, m_ls_rdata);
            chk("debug", debug, exp_dbg);
            if (e_mreq[mk]) begin
                chk("mem_addr", 32'(mem_addr), 32'(e_addr[mk]));
                chk("mem_we", 32'(mem_we), 32'(e_we[mk]));
                if (e_we[mk]) chk("mem_wdata", mem_wdata, e_wdata[mk]);
            end
            e_if_gnt[mk] = 0; e_ls_gnt[mk] = 0; e_mreq[mk] = 0; e_we[mk] = 0;
            e_busy[mk] = 0; e_if_rv[mk] = 0; e_ls_rv[mk] = 0; e_upd[mk] = 0;

            // A request seen while the arbiter is free starts a transaction.
            if (cyc >= next_free && (if_req || ls_req)) begin
                win_if = if_req && (!ls_req || starve_m >= MW);
                ms = (cyc + 1) % N;
                mr = (cyc + 2 + LAT) % N;
                e_mreq[ms]   = 1;
                e_if_gnt[ms] = win_if;
                e_ls_gnt[ms] = !win_if;
                e_addr[ms]   = win_if ? if_addr : ls_addr;
                e_we[ms]     = win_if ? 1'b0 : ls_we;
                e_wdata[ms]  = ls_wdata;
                for (int d = 1; d <= 2 + LAT; d++) e_busy[(cyc + d) % N] = 1;
                e_if_rv[mr] = win_if;
                e_ls_rv[mr] = !win_if;
                e_upd[mr]   = !e_we[ms];
                e_val[mr]   = mem_peek(e_addr[ms]);
                next_free   = cyc + 3 + LAT;
                if (win_if) starve_m = 0;
                else if (if_req && starve_m < 15) starve_m++;
            end
        end
    end

    // ---------------- requester tasks ----------------
    task automatic run_if(input logic [AW-1:0] a, output int tq, output int tg, output int tr,
                          output logic [DW-1:0] rd, output logic [AW-1:0] ga, output logic gw);
        tg = -1; tr = -1; rd = '0; ga = '0; gw = 1'b0;
        @(posedge clk); #1;
        if_req = 1'b1; if_addr = a; tq = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_gnt) begin tg = cyc; ga = mem_addr; gw = mem_we; break; end
        end
        if (tg < 0) fail_timeout("if_gnt_wait");
        @(posedge clk); #1;
        if_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (if_rvalid) begin tr = cyc; rd = if_rdata; break; end
        end
        if (tr < 0) fail_timeout("if_rvalid_wait");
    endtask

    task automatic run_ls(input logic [AW-1:0] a, input logic we, input logic [DW-1:0] wd,
                          output int tq, output int tg, output int tr, output logic [DW-1:0] rd,
                          output logic [AW-1:0] ga, output logic gw, output logic [DW-1:0] gd);
        tg = -1; tr = -1; rd = '0; ga = '0; gw = 1'b0; gd = '0;
        @(posedge clk); #1;
        ls_req = 1'b1; ls_addr = a; ls_we = we; ls_wdata = wd; tq = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ls_gnt) begin tg = cyc; ga = mem_addr; gw = mem_we; gd = mem_wdata; break; end
        end
        if (tg < 0) fail_timeout("ls_gnt_wait");
        @(posedge clk); #1;
        ls_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ls_rvalid) begin tr = cyc; rd = ls_rdata; break; end
        end
        if (tr < 0) fail_timeout("ls_rvalid_wait");
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) begin seen = 1; break; end
        end
        if (!seen) fail_timeout("idle_wait");
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int            tq, tg, tr, tq2, tg2, tr2, nls, nrv;
        logic [DW-1:0] rd, rd2, gd2;
        logic [AW-1:0] ga, ga2;
        logic          gw, gw2;
        bit            got;

        #1 reset = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_debug", debug, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // single IF read
        run_if(8'h10, tq, tg, tr, rd, ga, gw);
        chk("if1_gnt_lat", 32'(tg - tq), 32'd1);
        chk("if1_rv_lat", 32'(tr - tq), 32'd4);
        chk("if1_rdata", rd, 32'hDEAD_BEEF);
        chk("if1_addr", 32'(ga), 32'h10);
        chk("if1_we", 32'(gw), 32'd0);
        wait_idle();

        // simultaneous requests: LS first, IF on the following ISSUE
        fork
            run_if(8'h20, tq, tg, tr, rd, ga, gw);
            run_ls(8'h30, 1'b0, 32'h0, tq2, tg2, tr2, rd2, ga2, gw2, gd2);
        join
        chk("sim_ls_gnt_lat", 32'(tg2 - tq2), 32'd1);
        chk("sim_ls_addr", 32'(ga2), 32'h30);
        chk("sim_ls_rdata", rd2, 32'hCAFE_F00D);
        chk("sim_if_gnt_lat", 32'(tg - tq), 32'd6);
        chk("sim_if_addr", 32'(ga), 32'h20);
        chk("sim_if_rdata", rd, 32'h0BAD_C0DE);
        wait_idle();

        // LS write: ls_rdata keeps the previous load value
        run_ls(8'h05, 1'b1, 32'h1234_5678, tq2, tg2, tr2, rd2, ga2, gw2, gd2);
        chk("wr_we", 32'(gw2), 32'd1);
        chk("wr_addr", 32'(ga2), 32'h05);
        chk("wr_wdata", gd2, 32'h1234_5678);
        chk("wr_rv_lat", 32'(tr2 - tq2), 32'd4);
        chk("wr_rdata_hold", rd2, 32'hCAFE_F00D);
        wait_idle();
        run_ls(8'h05, 1'b0, 32'h0, tq2, tg2, tr2, rd2, ga2, gw2, gd2);
        chk("wr_readback", rd2, 32'h1234_5678);
        wait_idle();

        // starvation: LS re-requests continuously, IF wins the 5th arbitration
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h40;
        if_req = 1'b1; if_addr = 8'h50;
        nls = 0; got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ls_gnt) nls++;
            if (if_gnt) begin got = 1; break; end
        end
        if (!got) fail_timeout("starve_if_gnt");
        chk("starve_ls_wins", 32'(nls), 32'd4);
        @(posedge clk); #1;
        ls_req = 1'b0; if_req = 1'b0;
        wait_idle();

        // starvation count was cleared by the IF grant: LS wins again
        fork
            run_if(8'h60, tq, tg, tr, rd, ga, gw);
            run_ls(8'h61, 1'b0, 32'h0, tq2, tg2, tr2, rd2, ga2, gw2, gd2);
        join
        chk("post_starve_ls_lat", 32'(tg2 - tq2), 32'd1);
        chk("post_starve_if_lat", 32'(tg - tq), 32'd6);
        wait_idle();

        // reset in the middle of WAIT
        @(posedge clk); #1;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 8'h30;
        got = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ls_gnt) begin got = 1; break; end
        end
        if (!got) fail_timeout("mid_reset_gnt");
        @(posedge clk); #1;
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b0; ls_req = 1'b0;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_ls_rdata", ls_rdata, 32'd0);
        chk("mid_if_rdata", if_rdata, 32'd0);
        chk("mid_mem_req", 32'(mem_req), 32'd0);
        chk("mid_debug", debug, 32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        nrv = 0;
        repeat (10) begin
            @(negedge clk);
            if (if_rvalid || ls_rvalid) nrv++;
        end
        chk("mid_no_rvalid", 32'(nrv), 32'd0);
        chk("mid_idle", 32'(busy), 32'd0);

        // grant statistics: 3 IF grants and 2 LS grants since reset
        run_if(8'h10, tq, tg, tr, rd, ga, gw);
        run_if(8'h11, tq, tg, tr, rd, ga, gw);
        run_if(8'h12, tq, tg, tr, rd, ga, gw);
        run_ls(8'h10, 1'b0, 32'h0, tq2, tg2, tr2, rd2, ga2, gw2, gd2);
        run_ls(8'h13, 1'b1, 32'hA0B0_C0D0, tq2, tg2, tr2, rd2, ga2, gw2, gd2);
        wait_idle();
`ifdef ARB_DEBUG_EN
        chk("debug_counts", debug, 32'h0003_0002);
`else
        chk("debug_counts", debug, 32'h0);
`endif
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between two requesters:
  - the instruction-fetch port of the reader core (IF), which drives the ip/opcode path;
  - a load/store port (LS) for r0/r1 data traffic.
- Arbitrates by fixed priority (LS over IF) with IF starvation protection.
- Sequences each transaction through issue, wait and respond.
- Returns read data to the winning requester with a valid pulse.

Parameters:
- ADDR_W, 8, address width (matches the 8-bit instruction pointer).
- DATA_W, 32, data width (matches register width).
- MEM_LAT, 2, cycles from the mem_req cycle to valid mem_rdata; legal range 1..15.
- MAX_WAIT, 4, consecutive lost arbitrations after which IF wins; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  IF request; held high until if_gnt.
- if_addr  in  ADDR_W  IF fetch address.
- if_gnt  out  1  one-cycle grant pulse to IF.
- if_rvalid  out  1  one-cycle pulse: if_rdata is valid.
- if_rdata  out  DATA_W  fetched word.
- ls_req  in  1  LS request; held high until ls_gnt.
- ls_we  in  1  1 = write, 0 = read.
- ls_addr  in  ADDR_W  LS address.
- ls_wdata  in  DATA_W  LS write data.
- ls_gnt  out  1  one-cycle grant pulse to LS.
- ls_rvalid  out  1  one-cycle pulse: read data valid, or write acknowledged.
- ls_rdata  out  DATA_W  load data.
- mem_req  out  1  one-cycle memory strobe.
- mem_we  out  1  memory write enable; qualified by mem_req.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_req.
- busy  out  1  high whenever the state is not IDLE.
- debug  out  32  grant statistics (see Optional Feature).

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE;
  - all outputs and internal registers = 0, including rdata registers, wait counter and debug.
  - An in-flight transaction is abandoned: no rvalid is produced after reset deasserts.
- All outputs are registered.
- State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE, arbitration:
  - If exactly one request is high, that port is selected.
  - If both are high, LS wins, unless starve_cnt >= MAX_WAIT, in which case IF wins.
  - For the selected port, capture addr, we and wdata (IF: we = 0), then go to ISSUE.
  - With no request, stay in IDLE.
- starve_cnt:
  - Increments, saturating at 15, each time IF loses an arbitration with if_req high.
  - Clears when IF is granted.
- ISSUE (1 cycle):
  - Selected port's gnt = 1.
  - mem_req = 1; mem_addr, mem_we and mem_wdata carry the captured values.
  - Load a latency counter with MEM_LAT, then go to WAIT.
- WAIT:
  - Decrement the latency counter each cycle.
  - On the cycle mem_rdata is valid (MEM_LAT cycles after ISSUE): capture it if the transaction is a read, then go to RESP.
- RESP (1 cycle):
  - Selected port's rvalid = 1.
  - rdata is updated for reads only; writes pulse ls_rvalid with ls_rdata unchanged.
  - Go to IDLE.
- Timing: req seen at cycle t gives gnt and mem_req at t+1 and rvalid at t+2+MEM_LAT. The next grant is no earlier than t+4+MEM_LAT.
- Requests are ignored outside IDLE. A requester whose req stays high after gnt is treated as a new request at the next IDLE.
- if_rdata and ls_rdata hold their last value between responses.
- mem_req, gnt and rvalid are never high for more than one consecutive cycle per transaction.
- The unselected port never sees gnt or rvalid.

Optional Feature:
- Macro: ARB_DEBUG_EN.
- Defined:
  - debug = {if_grant_cnt[15:0], ls_grant_cnt[15:0]}.
  - Each count increments on its port's gnt pulse and wraps 16'hFFFF -> 0.
  - Both counts clear on reset.
- Undefined:
  - debug is tied to 32'h0 and no counter registers exist.
  - All other behaviour is identical.

Test Plan (MEM_LAT=2, MAX_WAIT=4):
- Single IF read: if_req=1, if_addr=8'h10 at cycle 0; memory returns 32'hDEADBEEF -> if_gnt and mem_req at cycle 1 with mem_addr=8'h10, mem_we=0; if_rvalid at cycle 4 with if_rdata=32'hDEADBEEF; busy is high during cycles 1-4.
- Simultaneous requests: IF (8'h20) and LS read (8'h30) both raised at cycle 0 -> LS is served first (mem_addr=8'h30 at cycle 1); IF is granted on the next ISSUE, at cycle 6, with mem_addr=8'h20.
- Starvation: if_req held high while LS re-requests continuously -> LS wins 4 consecutive arbitrations, IF wins the 5th, and starve_cnt returns to 0 after the IF grant.
- LS write: ls_we=1, ls_addr=8'h05, ls_wdata=32'h12345678 -> mem_we=1 with that address/data during ISSUE; ls_rvalid at cycle 4; ls_rdata is unchanged.
- Reset mid-operation: reset=0 during WAIT -> all outputs are 0 immediately (asynchronously); after release, no rvalid appears and the block is IDLE.
- ARB_DEBUG_EN defined, 3 IF grants and 2 LS grants -> debug=32'h0003_0002. ARB_DEBUG_EN undefined -> debug=0.
